// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
//   Shared LC-3b type definitions used by the memory arbiter and its helpers.
//   Contents:
//     lc3b_word            16-bit machine word / address
//     lc3b_mem_wmask       2-bit byte-enable mask for the memory port
//     lc3b_arb_state       arbiter FSM state {IDLE, I_BUSY, D_BUSY}
//     LC3B_MEM_WMASK_FULL  full-word byte enable (both bytes)
// ----------------------------------------------------------------------------
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } lc3b_arb_state;

   localparam lc3b_mem_wmask LC3B_MEM_WMASK_FULL = 2'b11;

endpackage

// File: rtl/lc3b_sat_counter.sv
// ----------------------------------------------------------------------------
// lc3b_sat_counter
//   Up-counter that stops at MAX_VAL instead of wrapping.
//   Parameters:
//     WIDTH    counter width in bits
//     MAX_VAL  saturation value (must fit in WIDTH bits)
//   Ports:
//     clk    in   clock
//     clr_n  in   synchronous active-low clear (takes priority over inc)
//     inc    in   increment enable
//     count  out  current count
// ----------------------------------------------------------------------------
module lc3b_sat_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = 15
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count_reg <= '0;
      end else if (inc && (count_reg != MAX_W)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// ----------------------------------------------------------------------------
// lc3b_mem_arbiter
//   Shares one LC-3b memory port between the instruction-fetch side (I, read
//   only) and the load/store side (D, read or write). One transaction is in
//   flight at a time. D has fixed priority over I, but after STARVE_LIMIT
//   consecutive D grants with I waiting, I is granted next.
//
//   Parameters:
//     STARVE_LIMIT  max consecutive D grants while I pends (1..15)
//
//   Ports:
//     clk, rst_n                  clock, synchronous active-low reset
//     i_read, i_address           I-side request (level, held until i_resp)
//     i_rdata, i_resp             I-side read data / one-cycle completion
//     d_read, d_write             D-side request (level, held until d_resp)
//     d_byte_enable, d_address,
//     d_wdata                     D-side request payload
//     d_rdata, d_resp             D-side read data / one-cycle completion
//     mem_read, mem_write,
//     mem_byte_enable,
//     mem_address, mem_wdata      registered memory request
//     mem_rdata, mem_resp         memory read data / completion
//
//   Optional build macro LC3B_ARB_PERF_CNT_EN adds saturating 16-bit
//   performance counters i_grant_cnt, d_grant_cnt and stall_cnt.
// ----------------------------------------------------------------------------
module lc3b_mem_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        i_read,
   input  logic [15:0] i_address,
   output logic [15:0] i_rdata,
   output logic        i_resp,

   input  logic        d_read,
   input  logic        d_write,
   input  logic [1:0]  d_byte_enable,
   input  logic [15:0] d_address,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_resp,

   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  mem_byte_enable,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp
`ifdef LC3B_ARB_PERF_CNT_EN
   ,
   output logic [15:0] i_grant_cnt,
   output logic [15:0] d_grant_cnt,
   output logic [15:0] stall_cnt
`endif
);

   localparam logic [3:0] STARVE_LIMIT_W = 4'(STARVE_LIMIT);

   lc3b_arb_state state_reg, state_next;

   logic          mem_read_reg,  mem_read_next;
   logic          mem_write_reg, mem_write_next;
   lc3b_mem_wmask mem_be_reg,    mem_be_next;
   lc3b_word      mem_addr_reg,  mem_addr_next;
   lc3b_word      mem_wdata_reg, mem_wdata_next;

   logic       d_req;
   logic       d_grant;
   logic       i_grant;
   logic [3:0] starve_cnt;

   // Arbitration only happens in IDLE; BUSY states ignore the requesters.
   always_comb begin
      d_req   = d_read | d_write;
      d_grant = 1'b0;
      i_grant = 1'b0;
      if (state_reg == IDLE) begin
         if (d_req && (!i_read || (starve_cnt < STARVE_LIMIT_W))) begin
            d_grant = 1'b1;
         end else if (i_read) begin
            i_grant = 1'b1;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      mem_read_next  = mem_read_reg;
      mem_write_next = mem_write_reg;
      mem_be_next    = mem_be_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;

      unique case (state_reg)
         IDLE: begin
            if (d_grant) begin
               state_next    = D_BUSY;
               mem_addr_next = d_address;
               // A simultaneous read+write request is treated as a write.
               if (d_write) begin
                  mem_read_next  = 1'b0;
                  mem_write_next = 1'b1;
                  mem_be_next    = d_byte_enable;
                  mem_wdata_next = d_wdata;
               end else begin
                  mem_read_next  = 1'b1;
                  mem_write_next = 1'b0;
                  mem_be_next    = LC3B_MEM_WMASK_FULL;
                  mem_wdata_next = d_wdata;
               end
            end else if (i_grant) begin
               state_next     = I_BUSY;
               mem_read_next  = 1'b1;
               mem_write_next = 1'b0;
               mem_be_next    = LC3B_MEM_WMASK_FULL;
               mem_addr_next  = i_address;
               mem_wdata_next = '0;
            end
         end
         I_BUSY, D_BUSY: begin
            // Returning to IDLE (rather than re-arbitrating here) guarantees
            // at least one idle cycle between transactions.
            if (mem_resp) begin
               state_next     = IDLE;
               mem_read_next  = 1'b0;
               mem_write_next = 1'b0;
            end
         end
         default: begin
            state_next     = IDLE;
            mem_read_next  = 1'b0;
            mem_write_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         mem_be_reg    <= 2'b00;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         mem_read_reg  <= mem_read_next;
         mem_write_reg <= mem_write_next;
         mem_be_reg    <= mem_be_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
      end
   end

   assign mem_read        = mem_read_reg;
   assign mem_write       = mem_write_reg;
   assign mem_byte_enable = mem_be_reg;
   assign mem_address     = mem_addr_reg;
   assign mem_wdata       = mem_wdata_reg;

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;
   assign i_resp  = mem_resp & (state_reg == I_BUSY);
   assign d_resp  = mem_resp & (state_reg == D_BUSY);

   // Starvation counter: counts D grants that bypassed a waiting I request;
   // any I grant resets it.
   lc3b_sat_counter #(
      .WIDTH   (4),
      .MAX_VAL (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk   (clk),
      .clr_n (rst_n & ~i_grant),
      .inc   (d_grant & i_read),
      .count (starve_cnt)
   );

`ifdef LC3B_ARB_PERF_CNT_EN
   logic stall_now;

   // A side is stalled whenever it is requesting and does not own the port.
   assign stall_now = (i_read & (state_reg != I_BUSY)) |
                      (d_req  & (state_reg != D_BUSY));

   lc3b_sat_counter #(.WIDTH(16), .MAX_VAL(16'hFFFF)) u_i_grant_cnt (
      .clk(clk), .clr_n(rst_n), .inc(i_grant), .count(i_grant_cnt)
   );

   lc3b_sat_counter #(.WIDTH(16), .MAX_VAL(16'hFFFF)) u_d_grant_cnt (
      .clk(clk), .clr_n(rst_n), .inc(d_grant), .count(d_grant_cnt)
   );

   lc3b_sat_counter #(.WIDTH(16), .MAX_VAL(16'hFFFF)) u_stall_cnt (
      .clk(clk), .clr_n(rst_n), .inc(stall_now), .count(stall_cnt)
   );
`endif

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lc3b_mem_arbiter
//   Directed self-checking bench for lc3b_mem_arbiter (STARVE_LIMIT = 4).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   at the same point, away from the active edge.
//   With LC3B_ARB_PERF_CNT_EN defined the grant counters are also checked.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lc3b_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_read;
   logic [15:0] i_address;
   logic [15:0] i_rdata;
   logic        i_resp;
   logic        d_read;
   logic        d_write;
   logic [1:0]  d_byte_enable;
   logic [15:0] d_address;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_resp;
`ifdef LC3B_ARB_PERF_CNT_EN
   logic [15:0] i_grant_cnt;
   logic [15:0] d_grant_cnt;
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lc3b_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_read          (i_read),
      .i_address       (i_address),
      .i_rdata         (i_rdata),
      .i_resp          (i_resp),
      .d_read          (d_read),
      .d_write         (d_write),
      .d_byte_enable   (d_byte_enable),
      .d_address       (d_address),
      .d_wdata         (d_wdata),
      .d_rdata         (d_rdata),
      .d_resp          (d_resp),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp)
`ifdef LC3B_ARB_PERF_CNT_EN
      ,
      .i_grant_cnt     (i_grant_cnt),
      .d_grant_cnt     (d_grant_cnt),
      .stall_cnt       (stall_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a memory request, check its address and kind,
   // then complete it with one mem_resp pulse.
   task automatic serve(input string tag, input logic [15:0] exp_addr,
                        input logic exp_wr, input logic [15:0] rdata);
      int n;
      n = 0;
      while (!(mem_read | mem_write) && n < 10) begin
         step();
         n++;
      end
      chk({tag, "_req_seen"}, 16'(mem_read | mem_write), 16'h1);
      chk({tag, "_addr"}, mem_address, exp_addr);
      chk({tag, "_wr"}, 16'(mem_write), 16'(exp_wr));
      $display("txn %s addr=%h wr=%0d rd=%0d be=%b", tag, mem_address,
               mem_write, mem_read, mem_byte_enable);
      mem_rdata = rdata;
      mem_resp  = 1'b1;
      step();
      mem_resp  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_byte_enable = 2'b00;
      d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
      step();
      step();

      // ---- reset state ----
      chk("rst_mem_read",  16'(mem_read), 16'h0);
      chk("rst_mem_write", 16'(mem_write), 16'h0);
      chk("rst_mem_be",    16'(mem_byte_enable), 16'h0);
      chk("rst_mem_addr",  mem_address, 16'h0);
      chk("rst_mem_wdata", mem_wdata, 16'h0);
      chk("rst_i_resp",    16'(i_resp), 16'h0);
      chk("rst_d_resp",    16'(d_resp), 16'h0);
      $display("txn reset state checked");
      rst_n = 1'b1;
      step();

      // ---- reset in the middle of a D write ----
      d_write = 1'b1; d_address = 16'h1234; d_wdata = 16'h5678; d_byte_enable = 2'b11;
      step();
      chk("midrst_write_on", 16'(mem_write), 16'h1);
      chk("midrst_addr",     mem_address, 16'h1234);
      d_write = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst_write_off", 16'(mem_write), 16'h0);
      mem_resp = 1'b1;
      #1;
      chk("midrst_d_resp", 16'(d_resp), 16'h0);
      chk("midrst_i_resp", 16'(i_resp), 16'h0);
      step();
      mem_resp = 1'b0;
      chk("midrst_idle_rd", 16'(mem_read), 16'h0);
      chk("midrst_idle_wr", 16'(mem_write), 16'h0);
      $display("txn reset mid-D_BUSY done");
      step();

      // ---- single I read, exact cycle timing ----
      i_read = 1'b1; i_address = 16'h0040;        // cycle 0
      step();                                     // cycle 1
      chk("iread_c1_rd",   16'(mem_read), 16'h1);
      chk("iread_c1_addr", mem_address, 16'h0040);
      chk("iread_c1_be",   16'(mem_byte_enable), 16'h3);
      chk("iread_c1_wd",   mem_wdata, 16'h0);
      step();                                     // cycle 2
      chk("iread_c2_rd",   16'(mem_read), 16'h1);
      chk("iread_c2_resp", 16'(i_resp), 16'h0);
      step();                                     // cycle 3
      mem_rdata = 16'hBEEF; mem_resp = 1'b1;
      #1;
      chk("iread_c3_resp",  16'(i_resp), 16'h1);
      chk("iread_c3_rdata", i_rdata, 16'hBEEF);
      chk("iread_c3_dresp", 16'(d_resp), 16'h0);
      i_read = 1'b0;
      step();                                     // cycle 4
      mem_resp = 1'b0;
      chk("iread_c4_rd",   16'(mem_read), 16'h0);
      chk("iread_c4_resp", 16'(i_resp), 16'h0);
      $display("txn single I read addr=0040 rdata=BEEF");

      // ---- mem_resp while IDLE is ignored ----
      mem_resp = 1'b1;
      #1;
      chk("idle_resp_i", 16'(i_resp), 16'h0);
      chk("idle_resp_d", 16'(d_resp), 16'h0);
      step();
      mem_resp = 1'b0;
      chk("idle_resp_nogrant", 16'(mem_read | mem_write), 16'h0);
      $display("txn stray mem_resp in IDLE");

      // ---- simultaneous I and D: D first, one IDLE gap, then I ----
      i_read = 1'b1; i_address = 16'h0040;
      d_write = 1'b1; d_address = 16'h2000; d_wdata = 16'h00AA; d_byte_enable = 2'b01;
      step();
      chk("sim_d_wr",    16'(mem_write), 16'h1);
      chk("sim_d_rd",    16'(mem_read), 16'h0);
      chk("sim_d_addr",  mem_address, 16'h2000);
      chk("sim_d_be",    16'(mem_byte_enable), 16'h1);
      chk("sim_d_wdata", mem_wdata, 16'h00AA);
      mem_resp = 1'b1;
      #1;
      chk("sim_d_resp", 16'(d_resp), 16'h1);
      chk("sim_i_noresp", 16'(i_resp), 16'h0);
      d_write = 1'b0;
      step();
      mem_resp = 1'b0;
      chk("sim_gap", 16'(mem_read | mem_write), 16'h0);
      step();
      chk("sim_i_rd",   16'(mem_read), 16'h1);
      chk("sim_i_addr", mem_address, 16'h0040);
      chk("sim_i_be",   16'(mem_byte_enable), 16'h3);
      chk("sim_i_wd",   mem_wdata, 16'h0);
      mem_resp = 1'b1;
      #1;
      chk("sim_i_resp", 16'(i_resp), 16'h1);
      i_read = 1'b0;
      step();
      mem_resp = 1'b0;
      $display("txn simultaneous D(2000) then I(0040)");

      // ---- starvation guard: 4 D grants, then I, then D ----
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      i_read = 1'b1; i_address = 16'h0100;
      d_read = 1'b1; d_address = 16'h0200;
      serve("starve_d1", 16'h0200, 1'b0, 16'h0001);
      serve("starve_d2", 16'h0200, 1'b0, 16'h0002);
      serve("starve_d3", 16'h0200, 1'b0, 16'h0003);
      serve("starve_d4", 16'h0200, 1'b0, 16'h0004);
      serve("starve_i",  16'h0100, 1'b0, 16'h0005);
      serve("starve_d5", 16'h0200, 1'b0, 16'h0006);
      i_read = 1'b0; d_read = 1'b0;
      step();

      // ---- read/write conflict, then drop d_write mid-transaction ----
      d_read = 1'b1; d_write = 1'b1;
      d_address = 16'h3000; d_wdata = 16'h1111; d_byte_enable = 2'b10;
      step();
      chk("rw_wr", 16'(mem_write), 16'h1);
      chk("rw_rd", 16'(mem_read), 16'h0);
      chk("rw_be", 16'(mem_byte_enable), 16'h2);
      d_write = 1'b0;
      step();
      chk("rw_drop_wr",   16'(mem_write), 16'h1);
      chk("rw_drop_rd",   16'(mem_read), 16'h0);
      chk("rw_drop_addr", mem_address, 16'h3000);
      mem_resp = 1'b1;
      #1;
      chk("rw_d_resp", 16'(d_resp), 16'h1);
      d_read = 1'b0;
      step();
      mem_resp = 1'b0;
      chk("rw_done", 16'(mem_read | mem_write), 16'h0);
      $display("txn read/write conflict addr=3000 served as write");

`ifdef LC3B_ARB_PERF_CNT_EN
      // ---- performance counters: 3 I grants, 2 D grants ----
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("perf_rst_i", i_grant_cnt, 16'h0);
      chk("perf_rst_d", d_grant_cnt, 16'h0);
      for (int k = 0; k < 3; k++) begin
         i_read = 1'b1; i_address = 16'h0400;
         serve("perf_i", 16'h0400, 1'b0, 16'h0);
         i_read = 1'b0;
         step();
      end
      for (int k = 0; k < 2; k++) begin
         d_read = 1'b1; d_address = 16'h0500;
         serve("perf_d", 16'h0500, 1'b0, 16'h0);
         d_read = 1'b0;
         step();
      end
      chk("perf_i_cnt", i_grant_cnt, 16'd3);
      chk("perf_d_cnt", d_grant_cnt, 16'd2);
      $display("txn perf counters i=%0d d=%0d stall=%0d", i_grant_cnt, d_grant_cnt, stall_cnt);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
